// File: rtl/cast_inject_arbiter.sv
// Round-robin packet arbiter injecting NREQ send queues onto one credit-controlled cast port.
// One cycle of arbitration in IDLE; a grant is held from HEAD through TAIL and stalls without loss.
`ifndef DW
`define DW 32
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif
`ifndef BUFFER_ALLOC
`define BUFFER_ALLOC 8
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module cast_inject_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = `DW,
    parameter int PKT_LEN     = `PKT_LEN,
    parameter int CREDIT_INIT = `BUFFER_ALLOC
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*8-1:0] req_cnt,
    output logic [NREQ-1:0]   req_ready,
    output logic              valid_o,
    output logic [DW-1:0]     data_o,
    input  logic              ready_i,
    input  logic              credit_upd,
    output logic [7:0]        grant_id,
    output logic              busy
);
    localparam logic [7:0] PKT_LEN8 = 8'(PKT_LEN);
    localparam logic [7:0] CRED_MAX = 8'(CREDIT_INIT);

    typedef enum logic {IDLE, SEND} state_e;

    state_e          state_q, state_d;
    logic [7:0]      credits_q, credits_d;
    logic [7:0]      grant_q, grant_d;
    logic [7:0]      last_q, last_d;
    logic [NREQ-1:0] elig;
    logic            pick_vld;
    logic [7:0]      pick;
    logic [DW-1:0]   gdata;
    logic            gvalid;
    logic            xfer;

    // A queue may only start a packet when the whole packet is buffered and fits downstream.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && (req_data[i*DW+DW-1 -: 2] == `HEAD) &&
                      (req_cnt[i*8 +: 8] >= PKT_LEN8) && (credits_q >= PKT_LEN8);
        end
    end

    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_vld && elig[i] && (i == (int'(last_q) + k) % NREQ)) begin
                    pick_vld = 1'b1;
                    pick     = 8'(i);
                end
            end
        end
    end

    always_comb begin
        gdata  = '0;
        gvalid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == 8'(i)) begin
                gdata  = req_data[i*DW +: DW];
                gvalid = req_valid[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        valid_o   = 1'b0;
        data_o    = '0;
        req_ready = '0;
        busy      = 1'b0;
        grant_id  = '0;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy     = 1'b1;
                grant_id = grant_q;
                valid_o  = gvalid && (credits_q != 8'd0);
                data_o   = gdata;
                xfer     = valid_o && ready_i;
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = xfer && (grant_q == 8'(i));
                end
                if (xfer && (gdata[DW-1 -: 2] == `TAIL)) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        if (xfer && !credit_upd) begin
            credits_d = credits_q - 8'd1;
        end else if (!xfer && credit_upd && (credits_q < CRED_MAX)) begin
            credits_d = credits_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            credits_q <= CRED_MAX;
            grant_q   <= '0;
            last_q    <= 8'(NREQ - 1);
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
        end
    end
endmodule

// File: tb/tb_cast_inject_arbiter.sv
// Bench for cast_inject_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_cast_inject_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int PL   = 4;
    localparam int CI   = 8;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b10;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ*8-1:0]   req_cnt = '0;
    logic [NREQ-1:0]     req_ready;
    logic                valid_o;
    logic [DW-1:0]       data_o;
    logic                ready_i = 1'b0;
    logic                credit_upd = 1'b0;
    logic [7:0]          grant_id;
    logic                busy;

    cast_inject_arbiter #(.NREQ(NREQ), .DW(DW), .PKT_LEN(PL), .CREDIT_INIT(CI)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_cnt(req_cnt), .req_ready(req_ready), .valid_o(valid_o), .data_o(data_o),
        .ready_i(ready_i), .credit_upd(credit_upd), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Queue contents visible to the DUT, and flits still arriving behind them.
    logic [DW-1:0] q    [NREQ][$];
    logic [DW-1:0] pend [NREQ][$];

    // Packet-level reference: who owns the port, who was served last, credits in flight.
    int m_send  = 0;
    int m_grant = 0;
    int m_last  = NREQ - 1;
    int m_cred  = CI;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push_pkt(input int qi, input bit direct);
        logic [DW-1:0] f;
        for (int n = 0; n < PL; n++) begin
            f = DW'($urandom);
            if (n == 0)              f[DW-1 -: 2] = T_HEAD;
            else if (n == PL - 1)    f[DW-1 -: 2] = T_TAIL;
            else if ($urandom_range(0, 3) == 0) f[DW-1 -: 2] = T_HEAD;
            else                     f[DW-1 -: 2] = T_BODY;
            if (direct) q[qi].push_back(f);
            else        pend[qi].push_back(f);
        end
    endtask

    task automatic drive_queues();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = (q[i].size() > 0);
            req_data[i*DW +: DW]   = (q[i].size() > 0) ? q[i][0] : '0;
            req_cnt[i*8 +: 8]      = (q[i].size() > 255) ? 8'd255 : 8'(q[i].size());
        end
    endtask

    function automatic bit eligible(input int i);
        logic [DW-1:0] f;
        if (q[i].size() < PL || m_cred < PL) return 1'b0;
        f = q[i][0];
        return f[DW-1 -: 2] == T_HEAD;
    endfunction

    task automatic cycle(input bit rdy, input bit upd);
        int g;
        bit was_send, e_valid, xfer;
        logic [DW-1:0] e_data, f;
        logic [NREQ-1:0] e_ready;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i].size() > 0 && $urandom_range(0, 1) == 1)
                q[i].push_back(pend[i].pop_front());
        end
        drive_queues();
        ready_i    = rdy;
        credit_upd = upd;
        #1;
        g        = m_grant;
        was_send = (m_send != 0);
        e_valid  = was_send && q[g].size() > 0 && m_cred > 0;
        e_data   = (was_send && q[g].size() > 0) ? q[g][0] : '0;
        e_ready  = (e_valid && rdy) ? (NREQ'(1) << g) : '0;
        chk("busy",      32'(busy),      32'(was_send));
        chk("grant_id",  32'(grant_id),  was_send ? 32'(g) : 32'd0);
        chk("valid_o",   32'(valid_o),   32'(e_valid));
        chk("data_o",    32'(data_o),    32'(e_data));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        xfer = e_valid && rdy;
        if (was_send) begin
            if (xfer) begin
                f = q[g].pop_front();
                if (f[DW-1 -: 2] == T_TAIL) begin
                    m_last = g;
                    m_send = 0;
                end
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                if (m_send == 0 && eligible((m_last + k) % NREQ)) begin
                    m_grant = (m_last + k) % NREQ;
                    m_send  = 1;
                end
            end
        end
        if (xfer && !upd)      m_cred = m_cred - 1;
        else if (!xfer && upd) m_cred = (m_cred < CI) ? m_cred + 1 : CI;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_valid"}, 32'(valid_o),   32'd0);
        chk({tag, "_data"},  32'(data_o),    32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_grant"}, 32'(grant_id),  32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            q[i].delete();
            pend[i].delete();
        end
        m_send  = 0;
        m_grant = 0;
        m_last  = NREQ - 1;
        m_cred  = CI;
    endtask

    initial begin
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Single packet from queue 2 consumes four credits.
        push_pkt(2, 1'b1);
        for (int n = 0; n < 8; n++) cycle(1'b1, 1'b0);
        for (int n = 0; n < 4; n++) cycle(1'b1, 1'b1);

        // Two always-eligible queues with a credit returned on every flit.
        for (int n = 0; n < 2; n++) begin
            push_pkt(0, 1'b1);
            push_pkt(1, 1'b1);
        end
        for (int n = 0; n < 24; n++) cycle(1'b1, 1'b1);

        // Credit exhaustion blocks the third packet until four credits return.
        for (int n = 0; n < 3; n++) push_pkt(3, 1'b1);
        for (int n = 0; n < 20; n++) cycle(1'b1, 1'b0);
        for (int n = 0; n < 4; n++)  cycle(1'b1, 1'b1);
        for (int n = 0; n < 10; n++) cycle(1'b1, 1'b0);
        for (int n = 0; n < 8; n++)  cycle(1'b1, 1'b1);

        // Downstream stall after the second flit.
        push_pkt(1, 1'b1);
        for (int n = 0; n < 3; n++) cycle(1'b1, 1'b0);
        for (int n = 0; n < 3; n++) cycle(1'b0, 1'b0);
        for (int n = 0; n < 5; n++) cycle(1'b1, 1'b1);

        // Reset in the middle of a packet, then all queues compete from a clean start.
        push_pkt(2, 1'b1);
        for (int n = 0; n < 3; n++) cycle(1'b1, 1'b0);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_idle_outputs("midrst");
        model_reset();
        drive_queues();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < NREQ; i++) push_pkt(i, 1'b1);
        for (int n = 0; n < 25; n++) cycle(1'b1, 1'b1);

        // Random traffic with trickling queues, stalls and sporadic credit returns.
        for (int n = 0; n < 3000; n++) begin
            int qi;
            qi = int'($urandom_range(0, NREQ - 1));
            if (pend[qi].size() < 8 && $urandom_range(0, 3) == 0) push_pkt(qi, 1'b0);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
